// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Burst-limited ownership; read data is returned to the port that issued it.
module dmem_port_arbiter #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 9,
   parameter int MAX_BURST = 4,
   parameter bit CORE_PRIO = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              wr,
   output logic              rd,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic [DATA_W-1:0] rd_data,
   output logic [1:0]        owner
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_P0   = 2'b01,
      OWN_P1   = 2'b10
   } owner_e;

   owner_e          owner_q, owner_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            last_q, last_d;
   logic            rpend_q, rpend_d;
   logic            rport_q, rport_d;
   logic            win0, win1;

   always_comb begin
      win0 = 1'b0;
      win1 = 1'b0;
      if (owner_q == OWN_P0 && req0) begin
         if (!req1 || cnt_q < MAXC) win0 = 1'b1;
         else                       win1 = 1'b1;
      end else if (owner_q == OWN_P1 && req1) begin
         if (!req0 || cnt_q < MAXC) win1 = 1'b1;
         else                       win0 = 1'b1;
      end else if (req0 && req1) begin
         // last_q: 1 = port1 was last owner
         if (CORE_PRIO || last_q) win0 = 1'b1;
         else                     win1 = 1'b1;
      end else begin
         win0 = req0;
         win1 = req1;
      end
   end

   assign gnt0 = win0 & reset;
   assign gnt1 = win1 & reset;

   assign wr      = (gnt0 & we0) | (gnt1 & we1);
   assign rd      = (gnt0 & ~we0) | (gnt1 & ~we1);
   assign addr    = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
   assign wr_data = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

   assign rvalid0 = rpend_q & ~rport_q;
   assign rvalid1 = rpend_q & rport_q;
   assign rdata0  = rvalid0 ? rd_data : '0;
   assign rdata1  = rvalid1 ? rd_data : '0;
   assign owner   = owner_q;

   always_comb begin
      owner_d = OWN_NONE;
      cnt_d   = '0;
      last_d  = last_q;
      rpend_d = rd;
      rport_d = gnt1;
      if (gnt0)      owner_d = OWN_P0;
      else if (gnt1) owner_d = OWN_P1;
      if (gnt0 || gnt1) begin
         last_d = gnt1;
         if (owner_d != owner_q) cnt_d = CW'(1);
         else if (cnt_q == MAXC) cnt_d = cnt_q;
         else                    cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q <= OWN_NONE;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         rpend_q <= 1'b0;
         rport_q <= 1'b0;
      end else begin
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         rpend_q <= rpend_d;
         rport_q <= rport_d;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural 512-word memory.
// Instance u_a uses CORE_PRIO=1, u_b uses CORE_PRIO=0 on the same stimulus.
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [8:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, wr, rd;
   logic [31:0] rdata0, rdata1, wr_data, rd_data;
   logic [8:0]  addr;
   logic [1:0]  owner;
   logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_wr, b_rd;
   logic [31:0] b_rdata0, b_rdata1, b_wr_data;
   logic [8:0]  b_addr;
   logic [1:0]  b_owner;
   logic [31:0] mem [512];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.CORE_PRIO(1'b1)) u_a (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .wr(wr), .rd(rd),
      .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .owner(owner)
   );

   dmem_port_arbiter #(.CORE_PRIO(1'b0)) u_b (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
      .rdata0(b_rdata0), .rdata1(b_rdata1), .wr(b_wr), .rd(b_rd),
      .addr(b_addr), .wr_data(b_wr_data), .rd_data(rd_data), .owner(b_owner)
   );

   always @(posedge clk) begin
      if (wr) mem[addr] <= wr_data;
      if (rd) rd_data <= mem[addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      int pat [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      for (int i = 0; i < 512; i++) mem[i] = '0;
      mem[5] = 32'hDEADBEEF;
      rd_data = '0;
      idle();
      reset = 1'b0;

      // reset: combinational strobes held low despite requests
      cyc();
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b1;
      #1;
      chk("rst_gnt0", 32'(gnt0), 0);
      chk("rst_gnt1", 32'(gnt1), 0);
      chk("rst_wr", 32'(wr), 0);
      chk("rst_rd", 32'(rd), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_rvalid0", 32'(rvalid0), 0);
      chk("rst_addr", 32'(addr), 0);
      cyc(); idle(); reset = 1'b1;

      // read of mem[5] from port 0
      cyc();
      req0 = 1'b1; addr0 = 9'd5;
      #1;
      chk("rd_gnt0", 32'(gnt0), 1);
      chk("rd_gnt1", 32'(gnt1), 0);
      chk("rd_rd", 32'(rd), 1);
      chk("rd_wr", 32'(wr), 0);
      chk("rd_addr", 32'(addr), 5);
      cyc(); idle();
      #1;
      chk("rd_rvalid0", 32'(rvalid0), 1);
      chk("rd_rdata0", rdata0, 32'hDEADBEEF);
      chk("rd_rvalid1", 32'(rvalid1), 0);
      chk("rd_rdata1", rdata1, 0);
      chk("rd_owner", 32'(owner), 1);

      // tie from idle: A bursts per CORE_PRIO, B goes opposite last owner
      cyc();
      #1;
      chk("idle_owner", 32'(owner), 0);
      chk("idle_rvalid0", 32'(rvalid0), 0);
      for (int i = 0; i < 9; i++) begin
         cyc();
         req0 = 1'b1; req1 = 1'b1;
         #1;
         chk($sformatf("tie_gnt0[%0d]", i), 32'(gnt0), 32'(pat[i] == 0));
         chk($sformatf("tie_gnt1[%0d]", i), 32'(gnt1), 32'(pat[i] == 1));
         if (i == 0) begin
            chk("prio0_gnt1", 32'(b_gnt1), 1);
            chk("prio0_gnt0", 32'(b_gnt0), 0);
         end
      end
      cyc(); idle();

      // owner release: port1 owns, drops after two grants
      cyc();
      req1 = 1'b1;
      #1;
      chk("rel_g1a", 32'(gnt1), 1);
      cyc();
      req0 = 1'b1;
      #1;
      chk("rel_g1b", 32'(gnt1), 1);
      chk("rel_g0b", 32'(gnt0), 0);
      cyc();
      req1 = 1'b0;
      #1;
      chk("rel_g0c", 32'(gnt0), 1);
      chk("rel_g1c", 32'(gnt1), 0);
      cyc(); idle();
      #1;
      chk("rel_owner", 32'(owner), 1);

      // write from port 1, read back on port 0
      cyc();
      req1 = 1'b1; we1 = 1'b1; addr1 = 9'h1FF; wdata1 = 32'h12345678;
      #1;
      chk("wr_gnt1", 32'(gnt1), 1);
      chk("wr_wr", 32'(wr), 1);
      chk("wr_rd", 32'(rd), 0);
      chk("wr_addr", 32'(addr), 32'h1FF);
      chk("wr_data", wr_data, 32'h12345678);
      cyc(); idle();
      req0 = 1'b1; addr0 = 9'h1FF;
      #1;
      chk("wr_rvalid1", 32'(rvalid1), 0);
      chk("wr_rvalid0", 32'(rvalid0), 0);
      chk("wrrd_gnt0", 32'(gnt0), 1);
      cyc(); idle();
      #1;
      chk("wrrd_rvalid0", 32'(rvalid0), 1);
      chk("wrrd_rdata0", rdata0, 32'h12345678);
      chk("wrrd_rvalid1", 32'(rvalid1), 0);

      // reset right after a granted read
      cyc();
      req0 = 1'b1; addr0 = 9'd5;
      #1;
      chk("mrst_gnt0", 32'(gnt0), 1);
      cyc(); idle();
      req1 = 1'b1; reset = 1'b0;
      #1;
      chk("mrst_rvalid0", 32'(rvalid0), 0);
      chk("mrst_rdata0", rdata0, 0);
      chk("mrst_gnt1", 32'(gnt1), 0);
      chk("mrst_rd", 32'(rd), 0);
      chk("mrst_owner", 32'(owner), 0);
      cyc();
      #1;
      chk("mrst_rvalid0b", 32'(rvalid0), 0);
      cyc(); idle(); reset = 1'b1;
      #1;
      chk("post_owner", 32'(owner), 0);
      cyc();
      req0 = 1'b1; req1 = 1'b1;
      #1;
      chk("post_gnt0", 32'(gnt0), 1);
      chk("post_gnt1", 32'(gnt1), 0);
      chk("post_b_gnt0", 32'(b_gnt0), 1);
      cyc(); idle();
      #1;
      chk("post_owner2", 32'(owner), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   always @(negedge clk) begin
      if (reset && (gnt0 && gnt1)) begin
         checks++;
         errors++;
         $error("FAIL both_gnt observed=11 expected=not both");
      end
   end

endmodule
